// File: rtl/fp_mul_serial_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_mul_serial_param: bus-serial IEEE-754 multiplier with an iterative     |
// | mantissa multiplier and RNE. FPMUL_FLAGS_EN adds o_flags {inv,ovf,unf,inx}|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp_mul_serial_param #(
  parameter int EXP_W   = 11,
  parameter int MAN_W   = 52,
  parameter int BUS_W   = 8,
  parameter int MUL_CYC = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [BUS_W-1:0] i_data_in,
  output logic             o_busy,
  output logic [BUS_W-1:0] o_data_out,
  output logic             o_ready
`ifdef FPMUL_FLAGS_EN
  ,
  output logic [3:0]       o_flags
`endif
);

  localparam int c_w     = 1 + EXP_W + MAN_W;
  localparam int c_m     = MAN_W + 1;
  localparam int c_k     = (c_m + MUL_CYC - 1) / MUL_CYC;
  localparam int c_kt    = c_k * MUL_CYC;
  localparam int c_pw    = 2 * c_m;
  localparam int c_ew    = EXP_W + 2;
  localparam int c_n_in  = 2 * c_w / BUS_W;
  localparam int c_n_out = c_w / BUS_W;
  localparam int c_cnt_w = $clog2(c_n_in + MUL_CYC + 1);

  localparam logic [c_cnt_w-1:0] c_last_in  = c_cnt_w'(c_n_in - 1);
  localparam logic [c_cnt_w-1:0] c_last_mul = c_cnt_w'(MUL_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_out_end  = c_cnt_w'(c_n_out);
  localparam logic [c_ew-1:0]    c_bias     = c_ew'((2 ** (EXP_W - 1)) - 1);
  localparam logic [c_ew-1:0]    c_exp_max  = c_ew'((2 ** EXP_W) - 1);
  localparam logic [c_w-1:0]     c_qnan     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [1:0] c_sp_none = 2'd0;
  localparam logic [1:0] c_sp_nan  = 2'd1;
  localparam logic [1:0] c_sp_inf  = 2'd2;
  localparam logic [1:0] c_sp_zero = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_MUL = 3'd2, S_NORM = 3'd3, S_RND = 3'd4, S_OUT = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2*c_w-1:0]     r_in;
  logic [c_kt-1:0]      r_mb;
  logic [c_pw-1:0]      r_acc;
  logic                 r_sign;
  logic [1:0]           r_spec;
  logic [c_ew-1:0]      r_exp;
  logic [c_pw-1:0]      r_sig;
  logic [c_w-1:0]       r_res;
  logic                 r_busy;
  logic                 r_ready;
  logic [BUS_W-1:0]     r_dout;

  // Operand A occupies the low half of r_in, B the high half (LSB beat first).
  logic [2*c_w-1:0]     w_in_next;
  logic [EXP_W-1:0]     w_ea, w_eb;
  logic [MAN_W-1:0]     w_fa, w_fb;
  logic                 w_sa, w_sb;
  logic [c_m-1:0]       w_ma;
  logic [c_kt-1:0]      w_mb_load;
  logic [c_k-1:0]       w_chunk;
  logic [c_m+c_k-1:0]   w_pp;

  assign w_in_next = {i_data_in, r_in[2*c_w-1:BUS_W]};
  assign w_sa      = r_in[c_w-1];
  assign w_ea      = r_in[c_w-2 -: EXP_W];
  assign w_fa      = r_in[MAN_W-1:0];
  assign w_sb      = r_in[2*c_w-1];
  assign w_eb      = r_in[2*c_w-2 -: EXP_W];
  assign w_fb      = r_in[c_w+MAN_W-1:c_w];
  assign w_ma      = {1'b1, w_fa};
  assign w_mb_load = c_kt'({1'b1, w_in_next[c_w+MAN_W-1:c_w]});
  assign w_chunk   = r_mb[c_kt-1 -: c_k];
  assign w_pp      = (c_m+c_k)'(w_ma) * (c_m+c_k)'(w_chunk);

  logic w_a_ones, w_b_ones, w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic w_nan, w_msb;
  logic [1:0]        w_spec;
  logic [c_ew-1:0]   w_exp_n;
  logic [c_pw-1:0]   w_sig_n;

  assign w_a_ones = &w_ea;
  assign w_b_ones = &w_eb;
  assign w_a_zero = ~|w_ea;
  assign w_b_zero = ~|w_eb;
  assign w_a_nan  = w_a_ones & (|w_fa);
  assign w_b_nan  = w_b_ones & (|w_fb);
  assign w_a_inf  = w_a_ones & ~(|w_fa);
  assign w_b_inf  = w_b_ones & ~(|w_fb);
  assign w_nan    = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
  assign w_spec   = w_nan ? c_sp_nan :
                    (w_a_inf | w_b_inf) ? c_sp_inf :
                    (w_a_zero | w_b_zero) ? c_sp_zero : c_sp_none;
  assign w_msb    = r_acc[c_pw-1];
  assign w_exp_n  = c_ew'(w_ea) + c_ew'(w_eb) - c_bias + c_ew'(w_msb);
  // Normalised significand keeps its leading one at the top bit.
  assign w_sig_n  = w_msb ? r_acc : (r_acc << 1);

  logic [MAN_W-1:0]  w_frac;
  logic              w_g, w_r, w_s, w_up, w_ovf, w_unf;
  logic [MAN_W:0]    w_frac_r;
  logic [c_ew-1:0]   w_exp_f;
  logic [c_w-1:0]    w_res;

  assign w_frac   = r_sig[c_pw-2:c_m];
  assign w_g      = r_sig[c_m-1];
  assign w_r      = r_sig[c_m-2];
  assign w_s      = |r_sig[c_m-3:0];
  assign w_up     = w_g & (w_r | w_s | w_frac[0]);
  assign w_frac_r = {1'b0, w_frac} + (MAN_W+1)'(w_up);
  assign w_exp_f  = r_exp + c_ew'(w_frac_r[MAN_W]);
  assign w_ovf    = ~w_exp_f[c_ew-1] & (w_exp_f >= c_exp_max);
  assign w_unf    = w_exp_f[c_ew-1] | (w_exp_f == '0);

  always_comb begin
    w_res = {r_sign, w_exp_f[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
    if (r_spec == c_sp_nan)
      w_res = c_qnan;
    else if ((r_spec == c_sp_inf) || ((r_spec == c_sp_none) && w_ovf))
      w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if ((r_spec == c_sp_zero) || ((r_spec == c_sp_none) && w_unf))
      w_res = {r_sign, {(c_w-1){1'b0}}};
  end

`ifdef FPMUL_FLAGS_EN
  logic [3:0] r_flags;
  logic [3:0] w_flags;
  assign w_flags = {r_spec == c_sp_nan,
                    (r_spec == c_sp_none) & w_ovf,
                    (r_spec == c_sp_none) & w_unf,
                    (r_spec == c_sp_none) & (w_ovf | w_unf | w_g | w_r | w_s)};
  assign o_flags = r_flags;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_in    <= '0;
      r_mb    <= '0;
      r_acc   <= '0;
      r_sign  <= 1'b0;
      r_spec  <= c_sp_none;
      r_exp   <= '0;
      r_sig   <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_dout  <= '0;
`ifdef FPMUL_FLAGS_EN
      r_flags <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (i_enable && !r_busy) begin
            r_in <= w_in_next;
            if (r_cnt == c_last_in) begin
              r_state <= S_MUL;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_acc   <= '0;
              r_mb    <= w_mb_load;
            end else begin
              r_state <= S_LOAD;
              r_cnt   <= r_cnt + c_cnt_w'(1);
            end
          end
        end
        S_MUL: begin
          // Most-significant multiplier chunk first; the running sum shifts up.
          r_acc <= (r_acc << c_k) + c_pw'(w_pp);
          r_mb  <= r_mb << c_k;
          if (r_cnt == c_last_mul) begin
            r_state <= S_NORM;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        S_NORM: begin
          r_sign  <= w_sa ^ w_sb;
          r_spec  <= w_spec;
          r_exp   <= w_exp_n;
          r_sig   <= w_sig_n;
          r_state <= S_RND;
        end
        S_RND: begin
          r_res   <= w_res;
`ifdef FPMUL_FLAGS_EN
          r_flags <= w_flags;
`endif
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (r_cnt == c_out_end) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_ready <= 1'b1;
            r_dout  <= r_res[BUS_W-1:0];
            r_res   <= r_res >> BUS_W;
            r_cnt   <= r_cnt + c_cnt_w'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_ready    = r_ready;
  assign o_data_out = r_dout;

endmodule
`default_nettype wire
